// File: rtl/comms_pkg.sv
// Shared definitions for the comms link (master and slave sides).
//   FRAME_BITS / ADDR_BITS / DATA_BITS : frame geometry, MSB first
//   RW_BIT                             : R/W flag position in the frame (1 = read)
//   comms_state_t                      : frame decoder state
package comms_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADDR_BITS  = 7;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned RW_BIT     = 15;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    END
  } comms_state_t;

  function automatic logic addr_in_range(input logic [ADDR_BITS-1:0] addr,
                                         input int unsigned count);
    return 32'(addr) < count;
  endfunction

endpackage

// File: rtl/comms_slave_if.sv
// Bus bundle between the comms link / local logic and comms_slave.
//   i_sen/i_sck/i_sdat : serial link from the master (sen active low)
//   o_sout             : serial read data back to the master
//   i_reg_*            : local register load port
//   o_wr_*             : committed SPI write notification
//   o_frame_error      : bad-length frame pulse
interface comms_slave_if;
  import comms_pkg::*;

  logic                 i_sen;
  logic                 i_sck;
  logic                 i_sdat;
  logic                 o_sout;
  logic                 i_reg_we;
  logic [ADDR_BITS-1:0] i_reg_addr;
  logic [DATA_BITS-1:0] i_reg_data;
  logic                 o_wr_valid;
  logic [ADDR_BITS-1:0] o_wr_addr;
  logic [DATA_BITS-1:0] o_wr_data;
  logic                 o_frame_error;

  modport slave (
    input  i_sen, i_sck, i_sdat, i_reg_we, i_reg_addr, i_reg_data,
    output o_sout, o_wr_valid, o_wr_addr, o_wr_data, o_frame_error
  );

  modport master (
    output i_sen, i_sck, i_sdat, i_reg_we, i_reg_addr, i_reg_data,
    input  o_sout, o_wr_valid, o_wr_addr, o_wr_data, o_frame_error
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
//   i_clock, i_reset : destination clock, async active-high reset (flops clear to 0)
//   i_d              : asynchronous input bus
//   o_q              : synchronised output, 2 cycles of latency
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      meta <= '0;
      o_q  <= '0;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/comms_slave.sv
// SPI register responder: decodes 16-bit R/W frames from comms_master,
// returns read data on o_sout, reports committed writes and bad-length frames,
// and accepts local register loads.
//   i_clock, i_reset : system clock, async active-high reset
//   bus              : comms_slave_if.slave (serial link, local port, write/error reports)
module comms_slave
  import comms_pkg::*;
#(
  parameter int unsigned REG_COUNT = 16
) (
  input  logic          i_clock,
  input  logic          i_reset,
  comms_slave_if.slave  bus
);

  localparam int unsigned IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam int unsigned CNT_W = 5;

  logic [2:0] sync_q;
  logic       sen_s, sck_s, sdat_s;
  logic       sen_q, sck_q;
  logic       sen_fall, sen_rise, sck_rise, sck_fall;

  comms_state_t state, state_nx;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-2:0] rx;
  logic [FRAME_BITS-1:0] frame_next;
  logic [ADDR_BITS-1:0]  cmd_addr, spi_addr;
  logic [DATA_BITS-1:0]  spi_data;
  logic [DATA_BITS-1:0]  tx;
  logic                  rd_frame;
  logic                  cmd_done, commit;

  logic [DATA_BITS-1:0]  regs [REG_COUNT];

  logic                  sout;
  logic                  wr_valid;
  logic [ADDR_BITS-1:0]  wr_addr;
  logic [DATA_BITS-1:0]  wr_data;
  logic                  frame_error;

  sync_2ff #(.WIDTH(3)) u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     ({bus.i_sen, bus.i_sck, bus.i_sdat}),
    .o_q     (sync_q)
  );

  assign sen_s  = sync_q[2];
  assign sck_s  = sync_q[1];
  assign sdat_s = sync_q[0];

  // The synchroniser and edge registers clear to 0, so a sen held low through
  // reset release produces no falling edge and that frame is ignored.
  assign sen_fall = sen_q & ~sen_s;
  assign sen_rise = ~sen_q & sen_s;
  assign sck_rise = ~sck_q & sck_s;
  assign sck_fall = sck_q & ~sck_s;

  assign frame_next = {rx, sdat_s};
  assign cmd_addr   = frame_next[ADDR_BITS-1:0];
  assign spi_addr   = frame_next[RW_BIT-1 -: ADDR_BITS];
  assign spi_data   = frame_next[DATA_BITS-1:0];

  always_comb begin
    state_nx = state;
    cmd_done = 1'b0;
    commit   = 1'b0;
    if (sen_rise) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (sen_fall) state_nx = CMD;
        CMD: begin
          if (sck_rise && bit_cnt == CNT_W'(DATA_BITS - 1)) begin
            state_nx = DATA;
            cmd_done = 1'b1;
          end
        end
        DATA: begin
          if (sck_rise && bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
            state_nx = END;
            commit   = ~frame_next[RW_BIT];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sen_q       <= 1'b0;
      sck_q       <= 1'b0;
      bit_cnt     <= '0;
      rx          <= '0;
      tx          <= '0;
      rd_frame    <= 1'b0;
      sout        <= 1'b0;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_error <= 1'b0;
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      sen_q       <= sen_s;
      sck_q       <= sck_s;
      wr_valid    <= 1'b0;
      frame_error <= 1'b0;

      if (sen_rise)
        frame_error <= (state != IDLE) && (bit_cnt != CNT_W'(FRAME_BITS));

      // Count keeps running (saturating) in END so long frames are flagged.
      if (state == IDLE && sen_fall)
        bit_cnt <= '0;
      else if (state != IDLE && sck_rise && bit_cnt != '1)
        bit_cnt <= bit_cnt + 1'b1;

      if ((state == CMD || state == DATA) && sck_rise)
        rx <= frame_next[FRAME_BITS-2:0];

      if (cmd_done) begin
        rd_frame <= frame_next[DATA_BITS-1];
        tx       <= addr_in_range(cmd_addr, REG_COUNT) ? regs[cmd_addr[IDX_W-1:0]] : '0;
      end

      // First DATA-state falling edge is the 8th of the frame and presents bit 7.
      if (state == DATA && rd_frame) begin
        if (sck_fall) begin
          sout <= tx[DATA_BITS-1];
          tx   <= {tx[DATA_BITS-2:0], 1'b0};
        end
      end else begin
        sout <= 1'b0;
      end

      // Local load first so a same-address SPI commit below overrides it.
      if (bus.i_reg_we && addr_in_range(bus.i_reg_addr, REG_COUNT))
        regs[bus.i_reg_addr[IDX_W-1:0]] <= bus.i_reg_data;

      if (commit) begin
        wr_valid <= 1'b1;
        wr_addr  <= spi_addr;
        wr_data  <= spi_data;
        if (addr_in_range(spi_addr, REG_COUNT))
          regs[spi_addr[IDX_W-1:0]] <= spi_data;
      end
    end
  end

  assign bus.o_sout        = sout;
  assign bus.o_wr_valid    = wr_valid;
  assign bus.o_wr_addr     = wr_addr;
  assign bus.o_wr_data     = wr_data;
  assign bus.o_frame_error = frame_error;

endmodule

// File: tb/tb_comms_slave.sv
// Self-checking bench for comms_slave: table of SPI frames plus hand-written
// collision, local-port and reset-abort sequences; committed writes are
// checked against a queue of expected writes.
module tb_comms_slave;
  import comms_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  comms_slave_if bus();

  comms_slave #(.REG_COUNT(16)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    string      name;
    logic [15:0] frame;
    int          nbits;
    logic [7:0]  exp_rd;
    logic        exp_wr;
    logic [6:0]  wa;
    logic [7:0]  wd;
    logic        exp_err;
  } vec_t;

  wr_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   err_seen = 0;
  int   err_exp  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One low+high sck period per bit; sout sampled late in each low phase.
  task automatic spi_bits(input logic [15:0] frame, input int first, input int last,
                          inout logic [7:0] rd);
    for (int i = first; i <= last; i++) begin
      bus.i_sck  = 1'b0;
      bus.i_sdat = (i < 16) ? frame[15-i] : 1'b0;
      wait_cyc(8);
      if (i >= 8 && i <= 15) rd[15-i] = bus.o_sout;
      else check($sformatf("sout_quiet_bit%0d", i), bus.o_sout, 0);
      bus.i_sck = 1'b1;
      wait_cyc(8);
    end
  endtask

  task automatic spi_frame(input logic [15:0] frame, input int nbits, output logic [7:0] rd);
    logic [7:0] r;
    r = '0;
    bus.i_sen = 1'b0;
    wait_cyc(8);
    spi_bits(frame, 0, nbits - 1, r);
    bus.i_sck = 1'b0;
    wait_cyc(8);
    bus.i_sen = 1'b1;
    wait_cyc(10);
    rd = r;
  endtask

  // Write / frame-error monitor.
  initial begin
    logic prev_wv, prev_fe;
    wr_t  e;
    prev_wv = 1'b0;
    prev_fe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.o_wr_valid) begin
          check("wr_pulse_width", prev_wv, 0);
          if (exp_q.size() == 0) begin
            check("wr_unexpected", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", bus.o_wr_addr, e.addr);
            check("wr_data", bus.o_wr_data, e.data);
          end
        end
        if (bus.o_frame_error) begin
          check("ferr_pulse_width", prev_fe, 0);
          err_seen++;
        end
      end
      prev_wv = bus.o_wr_valid;
      prev_fe = bus.o_frame_error;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vt[10];
    logic [7:0] rd;
    logic       hit;

    vt[0] = '{"wr03",   16'h035A, 16, 8'h00, 1'b1, 7'h03, 8'h5A, 1'b0};
    vt[1] = '{"rd03",   16'h8300, 16, 8'h5A, 1'b0, 7'h00, 8'h00, 1'b0};
    vt[2] = '{"rd20",   16'hA000, 16, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0};
    vt[3] = '{"wr20",   16'h2077, 16, 8'h00, 1'b1, 7'h20, 8'h77, 1'b0};
    vt[4] = '{"rd00",   16'h8000, 16, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0};
    vt[5] = '{"rd20b",  16'hA000, 16, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0};
    vt[6] = '{"short",  16'h0599, 10, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1};
    vt[7] = '{"rd05",   16'h8500, 16, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0};
    vt[8] = '{"long",   16'h0744, 18, 8'h00, 1'b1, 7'h07, 8'h44, 1'b1};
    vt[9] = '{"rd07",   16'h8700, 16, 8'h44, 1'b0, 7'h00, 8'h00, 1'b0};

    bus.i_sen      = 1'b1;
    bus.i_sck      = 1'b0;
    bus.i_sdat     = 1'b0;
    bus.i_reg_we   = 1'b0;
    bus.i_reg_addr = '0;
    bus.i_reg_data = '0;

    wait_cyc(5);
    check("rst_sout",        bus.o_sout, 0);
    check("rst_wr_valid",    bus.o_wr_valid, 0);
    check("rst_wr_addr",     bus.o_wr_addr, 0);
    check("rst_wr_data",     bus.o_wr_data, 0);
    check("rst_frame_error", bus.o_frame_error, 0);
    rst = 1'b0;
    wait_cyc(10);

    for (int k = 0; k < 10; k++) begin
      if (vt[k].exp_wr) exp_q.push_back('{addr: vt[k].wa, data: vt[k].wd});
      if (vt[k].exp_err) err_exp++;
      spi_frame(vt[k].frame, vt[k].nbits, rd);
      check({vt[k].name, "_rdata"},   rd, vt[k].exp_rd);
      check({vt[k].name, "_wr_left"}, exp_q.size(), 0);
      check({vt[k].name, "_ferr"},    err_seen, err_exp);
    end

    // Local and SPI write to address 5 in the commit cycle: SPI must win.
    exp_q.push_back('{addr: 7'h05, data: 8'h22});
    hit = 1'b0;
    fork
      spi_frame(16'h0522, 16, rd);
      begin
        bus.i_reg_addr = 7'h05;
        bus.i_reg_data = 8'h11;
        bus.i_reg_we   = 1'b1;
        for (int c = 0; c < 2000; c++) begin
          @(negedge clk);
          if (bus.o_wr_valid) break;
        end
        hit = bus.o_wr_valid;
        bus.i_reg_we = 1'b0;
      end
    join
    check("coll_commit_seen", hit, 1);
    check("coll_wr_left", exp_q.size(), 0);
    spi_frame(16'h8500, 16, rd);
    check("coll_rd05", rd, 8'h22);

    // Local-only write, then an out-of-range local write that must not alias.
    bus.i_reg_addr = 7'h06;
    bus.i_reg_data = 8'hC3;
    bus.i_reg_we   = 1'b1;
    wait_cyc(1);
    bus.i_reg_addr = 7'h16;
    bus.i_reg_data = 8'h99;
    wait_cyc(1);
    bus.i_reg_we = 1'b0;
    wait_cyc(2);
    spi_frame(16'h8600, 16, rd);
    check("local_rd06", rd, 8'hC3);

    // Reset after bit 12 of a write: frame aborted, registers cleared.
    rd = '0;
    bus.i_sen = 1'b0;
    wait_cyc(8);
    spi_bits(16'h03AB, 0, 11, rd);
    bus.i_sck = 1'b0;
    wait_cyc(4);
    rst = 1'b1;
    wait_cyc(3);
    check("midrst_sout",     bus.o_sout, 0);
    check("midrst_wr_valid", bus.o_wr_valid, 0);
    check("midrst_ferr",     bus.o_frame_error, 0);
    rst = 1'b0;
    spi_bits(16'h03AB, 12, 15, rd);
    bus.i_sck = 1'b0;
    wait_cyc(8);
    bus.i_sen = 1'b1;
    wait_cyc(10);
    check("midrst_wr_left", exp_q.size(), 0);
    check("midrst_no_ferr", err_seen, err_exp);
    spi_frame(16'h8300, 16, rd);
    check("midrst_rd03", rd, 8'h00);
    spi_frame(16'h8500, 16, rd);
    check("midrst_rd05", rd, 8'h00);
    spi_frame(16'h8600, 16, rd);
    check("midrst_rd06", rd, 8'h00);
    spi_frame(16'h8700, 16, rd);
    check("midrst_rd07", rd, 8'h00);

    exp_q.push_back('{addr: 7'h0A, data: 8'h3C});
    spi_frame(16'h0A3C, 16, rd);
    check("post_wr_left", exp_q.size(), 0);
    spi_frame(16'h8A00, 16, rd);
    check("post_rd0a", rd, 8'h3C);
    check("post_ferr", err_seen, err_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
